lcd_write_scheduler: RTL and testbench



---
 rtl/lcd_write_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_lcd_write_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_scheduler.sv
// lcd_write_scheduler
//   Owns the Spartan-3E character LCD (4-bit mode). It runs the power-on
//   initialisation nibbles. After that it serves byte writes from two
//   requesters with round-robin arbitration. Each byte is sent as a high
//   nibble and then a low nibble, and the LCD setup, enable-width,
//   inter-nibble and execution delays are timed purely by counters.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   req0/req1           write request, held until the matching ack
//   rs0/rs1             0 = command byte, 1 = character data
//   data0/data1 [7:0]   byte to write
//   ack0/ack1           one-cycle pulse: request accepted, operands latched
//   ready               high only while idle and able to accept a request
//   init_done           high once the power-on sequence has completed
//   LCD_E, LCD_RS       LCD enable strobe and register select
//   LCD_RW              always 0 (write-only usage)
//   SF_D [3:0]          LCD data nibble (board pins SF_D[11:8])

module lcd_write_scheduler #(
    parameter int unsigned T_POWERUP = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_SHORT   = 2000,
    parameter int unsigned T_LONG    = 82000,
    parameter int unsigned T_NIBBLE  = 50,
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_EHIGH   = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       ready,
    output logic       init_done,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [3:0] SF_D
);

    // Counter width: wide enough for the longest wait, never below 20 bits.
    localparam int unsigned MAX_A  = (T_POWERUP > T_INIT1) ? T_POWERUP : T_INIT1;
    localparam int unsigned MAX_B  = (T_INIT2 > T_SHORT) ? T_INIT2 : T_SHORT;
    localparam int unsigned MAX_C  = (T_LONG > T_NIBBLE) ? T_LONG : T_NIBBLE;
    localparam int unsigned MAX_D  = (T_SETUP > T_EHIGH) ? T_SETUP : T_EHIGH;
    localparam int unsigned MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CD = (MAX_C > MAX_D) ? MAX_C : MAX_D;
    localparam int unsigned MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned NEED_W = unsigned'($clog2(MAX_T + 1));
    localparam int unsigned CW     = (NEED_W > 20) ? NEED_W : 20;

    // Each wait runs its counter from 0 to T-1, so the terminal value is T-1.
    localparam logic [CW-1:0] POWERUP_END = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] INIT1_END   = CW'(T_INIT1 - 1);
    localparam logic [CW-1:0] INIT2_END   = CW'(T_INIT2 - 1);
    localparam logic [CW-1:0] SHORT_END   = CW'(T_SHORT - 1);
    localparam logic [CW-1:0] LONG_END    = CW'(T_LONG - 1);
    localparam logic [CW-1:0] NIBBLE_END  = CW'(T_NIBBLE - 1);
    localparam logic [CW-1:0] SETUP_END   = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] EHIGH_END   = CW'(T_EHIGH - 1);

    // INIT_NIB is the setup phase of a power-on nibble. It has the same
    // timing as SETUP; a separate state keeps init and byte traffic apart.
    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_NIB,
        SETUP,
        E_HIGH,
        HOLD,
        NIB_GAP,
        EXEC_WAIT,
        IDLE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   exec_end;
    logic [1:0]      nib_idx;
    logic            low_nib;
    logic            last_grant;
    logic            lat_rs;
    logic [7:0]      lat_data;

    logic            grant0_c;
    logic            grant1_c;
    logic            is_long_cmd_c;

    // The LCD is never read; the busy flag is not polled.
    assign LCD_RW = 1'b0;

    // Round robin: on a tie, serve the port that was not served last.
    assign grant0_c = req0 & (~req1 | last_grant);
    assign grant1_c = req1 & (~req0 | ~last_grant);

    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    // 0x00 also matches; it is not a valid command, so the longer wait is harmless.
    assign is_long_cmd_c = ~lat_rs & (lat_data[7:1] == 7'd0);

    // Wait that follows each power-on nibble.
    function automatic logic [CW-1:0] init_wait_end(input logic [1:0] idx);
        case (idx)
            2'd0:    init_wait_end = INIT1_END;
            2'd1:    init_wait_end = INIT2_END;
            default: init_wait_end = SHORT_END;
        endcase
    endfunction

    // Sequencer: power-on init, arbitration, and nibble timing.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= PWR_WAIT;
            cnt        <= '0;
            exec_end   <= '0;
            nib_idx    <= 2'd0;
            low_nib    <= 1'b0;
            last_grant <= 1'b1;
            lat_rs     <= 1'b0;
            lat_data   <= 8'h00;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            ready      <= 1'b0;
            init_done  <= 1'b0;
            LCD_E      <= 1'b0;
            LCD_RS     <= 1'b0;
            SF_D       <= 4'h0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;

            case (state)
                PWR_WAIT: begin
                    if (cnt == POWERUP_END) begin
                        cnt     <= '0;
                        nib_idx <= 2'd0;
                        LCD_RS  <= 1'b0;
                        SF_D    <= 4'h3;
                        state   <= INIT_NIB;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                INIT_NIB, SETUP: begin
                    if (cnt == SETUP_END) begin
                        cnt   <= '0;
                        LCD_E <= 1'b1;
                        state <= E_HIGH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                E_HIGH: begin
                    if (cnt == EHIGH_END) begin
                        cnt   <= '0;
                        LCD_E <= 1'b0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // One cycle of data hold after LCD_E falls; then choose the next wait.
                HOLD: begin
                    cnt <= '0;
                    if (!init_done) begin
                        exec_end <= init_wait_end(nib_idx);
                        state    <= EXEC_WAIT;
                    end else if (!low_nib) begin
                        state <= NIB_GAP;
                    end else begin
                        exec_end <= is_long_cmd_c ? LONG_END : SHORT_END;
                        state    <= EXEC_WAIT;
                    end
                end

                NIB_GAP: begin
                    if (cnt == NIBBLE_END) begin
                        cnt     <= '0;
                        low_nib <= 1'b1;
                        SF_D    <= lat_data[3:0];
                        state   <= SETUP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                EXEC_WAIT: begin
                    if (cnt == exec_end) begin
                        cnt <= '0;
                        if (init_done) begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end else if (nib_idx == 2'd3) begin
                            init_done <= 1'b1;
                            ready     <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            // Power-on nibble order is 3, 3, 3, 2.
                            nib_idx <= nib_idx + 2'd1;
                            SF_D    <= (nib_idx == 2'd2) ? 4'h2 : 4'h3;
                            state   <= INIT_NIB;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Accept a request; the high nibble goes onto the bus at the same edge.
                IDLE: begin
                    cnt     <= '0;
                    low_nib <= 1'b0;
                    if (grant0_c) begin
                        ack0       <= 1'b1;
                        last_grant <= 1'b0;
                        lat_rs     <= rs0;
                        lat_data   <= data0;
                        LCD_RS     <= rs0;
                        SF_D       <= data0[7:4];
                        ready      <= 1'b0;
                        state      <= SETUP;
                    end else if (grant1_c) begin
                        ack1       <= 1'b1;
                        last_grant <= 1'b1;
                        lat_rs     <= rs1;
                        lat_data   <= data1;
                        LCD_RS     <= rs1;
                        SF_D       <= data1[7:4];
                        ready      <= 1'b0;
                        state      <= SETUP;
                    end
                end

                default: begin
                    cnt   <= '0;
                    LCD_E <= 1'b0;
                    state <= PWR_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// tb_lcd_write_scheduler
//   Scoreboard bench for lcd_write_scheduler. The stimulus side pushes
//   expected grants and init pulses into queues. A monitor samples on the
//   falling edge and checks acks, every LCD_E pulse, and the ready and
//   init_done timing. Expected times come from the published cycle formulas.

module tb_lcd_write_scheduler;

    localparam int T_POWERUP = 20;
    localparam int T_INIT1   = 10;
    localparam int T_INIT2   = 6;
    localparam int T_SHORT   = 4;
    localparam int T_LONG    = 9;
    localparam int T_NIBBLE  = 3;
    localparam int T_SETUP   = 2;
    localparam int T_EHIGH   = 12;
    localparam int NIB_CYC   = T_SETUP + T_EHIGH + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, rs0 = 1'b0, rs1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       ack0, ack1, ready, init_done;
    logic       LCD_E, LCD_RS, LCD_RW;
    logic [3:0] SF_D;

    lcd_write_scheduler #(
        .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
        .T_SHORT(T_SHORT), .T_LONG(T_LONG), .T_NIBBLE(T_NIBBLE),
        .T_SETUP(T_SETUP), .T_EHIGH(T_EHIGH)
    ) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1),
        .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .ready(ready), .init_done(init_done),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .SF_D(SF_D)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       port;
        bit       rs;
        bit [7:0] data;
        int       at;     // required ack cycle, or -1 if not pinned
    } grant_t;

    typedef struct {
        bit       rs;
        bit [3:0] nib;
        int       rise;
    } pulse_t;

    grant_t exp_q[$];
    pulse_t pulse_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_ready_cyc = -1;
    int exp_init_cyc  = -1;
    bit m_last = 1'b1;    // model of the last granted port

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    // ---------------- monitor ----------------
    bit       prev_e = 0, prev_ready = 0, prev_init = 0, prev_ack = 0;
    bit       e_active = 0;
    int       rise_cyc = 0;
    bit [3:0] cap_sfd, sfd_h1, sfd_h2;
    bit       cap_rs, rs_h1, rs_h2;

    always @(negedge clock) begin
        pulse_t p;
        grant_t g;
        int     exec_t;
        chk("rw_low", int'(LCD_RW), 0);
        if (reset) begin
            e_active = 0;
        end else begin
            if (LCD_E && !prev_e) begin
                if (pulse_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    p = pulse_q.pop_front();
                    chk("pulse_nibble", int'(SF_D), int'(p.nib));
                    chk("pulse_rs", int'(LCD_RS), int'(p.rs));
                    chk("pulse_rise_cycle", cyc, p.rise);
                end
                chk("setup_stable", int'(sfd_h1 == SF_D && sfd_h2 == SF_D &&
                                         rs_h1 == LCD_RS && rs_h2 == LCD_RS), 1);
                cap_sfd  = SF_D;
                cap_rs   = LCD_RS;
                rise_cyc = cyc;
                e_active = 1;
            end else if (LCD_E && e_active) begin
                chk("sfd_stable_e", int'(SF_D), int'(cap_sfd));
                chk("rs_stable_e", int'(LCD_RS), int'(cap_rs));
            end else if (!LCD_E && prev_e && e_active) begin
                chk("e_width", cyc - rise_cyc, T_EHIGH);
                chk("sfd_hold", int'(SF_D), int'(cap_sfd));
                chk("rs_hold", int'(LCD_RS), int'(cap_rs));
                e_active = 0;
            end

            if (ack0 || ack1) begin
                chk("ack_after_init", int'(init_done), 1);
                chk("ack_exclusive", int'(ack0 && ack1), 0);
                chk("ack_one_cycle", int'(prev_ack), 0);
                chk("ready_low_at_ack", int'(ready), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    g = exp_q.pop_front();
                    chk("ack_port", ack1 ? 1 : 0, int'(g.port));
                    if (g.at >= 0) chk("ack_cycle", cyc, g.at);
                    exec_t = (!g.rs && g.data[7:1] == 7'd0) ? T_LONG : T_SHORT;
                    pulse_q.push_back('{rs: g.rs, nib: g.data[7:4], rise: cyc + T_SETUP});
                    pulse_q.push_back('{rs: g.rs, nib: g.data[3:0],
                                        rise: cyc + NIB_CYC + T_NIBBLE + T_SETUP});
                    exp_ready_cyc = cyc + 2 * NIB_CYC + T_NIBBLE + exec_t;
                end
            end

            if (ready && !prev_ready) chk("ready_rise_cycle", cyc, exp_ready_cyc);
            if (init_done && !prev_init) chk("init_done_cycle", cyc, exp_init_cyc);
        end
        prev_e     = LCD_E;
        prev_ready = ready;
        prev_init  = init_done;
        prev_ack   = ack0 | ack1;
        sfd_h2 = sfd_h1; sfd_h1 = SF_D;
        rs_h2  = rs_h1;  rs_h1  = LCD_RS;
    end

    // ---------------- stimulus + reference model ----------------

    // Assert reset, check the immediate response, then queue the init pulses.
    task automatic do_reset(input int hold);
        int r;
        int t;
        int waits[4];
        bit [3:0] nibs[4];
        waits = '{T_INIT1, T_INIT2, T_SHORT, T_SHORT};
        nibs  = '{4'h3, 4'h3, 4'h3, 4'h2};
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        pulse_q.delete();
        m_last = 1'b1;
        @(negedge clock);
        chk("reset_lcd_e", int'(LCD_E), 0);
        chk("reset_init_done", int'(init_done), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_sfd", int'(SF_D), 0);
        repeat (hold) @(negedge clock);
        reset = 1'b0;
        r = cyc;   // last edge that sampled reset high
        t = r + T_POWERUP + T_SETUP;
        for (int i = 0; i < 4; i++) begin
            pulse_q.push_back('{rs: 1'b0, nib: nibs[i], rise: t});
            if (i < 3) t = t + T_EHIGH + 1 + waits[i] + T_SETUP;
        end
        exp_init_cyc  = t + T_EHIGH + 1 + T_SHORT;
        exp_ready_cyc = exp_init_cyc;
    endtask

    // Arbitration model: pattern 1 = port 0, 2 = port 1, 3 = both.
    task automatic model_push(input int pat, input bit r0, input bit [7:0] d0,
                              input bit r1, input bit [7:0] d1, input int at_first);
        bit first;
        grant_t g0, g1;
        g0 = '{port: 1'b0, rs: r0, data: d0, at: -1};
        g1 = '{port: 1'b1, rs: r1, data: d1, at: -1};
        if (pat == 3) begin
            first = ~m_last;
            if (first == 1'b0) begin
                g0.at = at_first;
                exp_q.push_back(g0); exp_q.push_back(g1); m_last = 1'b1;
            end else begin
                g1.at = at_first;
                exp_q.push_back(g1); exp_q.push_back(g0); m_last = 1'b0;
            end
        end else if (pat == 1) begin
            g0.at = at_first; exp_q.push_back(g0); m_last = 1'b0;
        end else begin
            g1.at = at_first; exp_q.push_back(g1); m_last = 1'b1;
        end
    endtask

    // Hold requests until acked, dropping each one the cycle after its ack.
    task automatic wait_acks(input int n);
        int left;
        int budget;
        left = n;
        budget = 0;
        while (left > 0 && budget < 2000) begin
            @(negedge clock);
            budget++;
            if (ack0 && req0) begin req0 = 1'b0; left--; end
            if (ack1 && req1) begin req1 = 1'b0; left--; end
        end
        if (left > 0) begin
            chk("ack_timeout", left, 0);
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    task automatic do_round(input int pat, input bit r0, input bit [7:0] d0,
                            input bit r1, input bit [7:0] d1);
        model_push(pat, r0, d0, r1, d1, -1);
        @(negedge clock);
        rs0 = r0; data0 = d0; rs1 = r1; data1 = d1;
        req0 = (pat == 1 || pat == 3);
        req1 = (pat == 2 || pat == 3);
        wait_acks((pat == 3) ? 2 : 1);
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!ready && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("ready_wait", int'(ready), 1);
    endtask

    initial begin
        int       pat;
        bit       r0, r1;
        bit [7:0] d0, d1;
        int       n;

        // Init sequence with req0 already pending: no ack before init_done.
        rs0 = 1'b1; data0 = 8'h41; req0 = 1'b1;
        do_reset(3);
        model_push(1, 1'b1, 8'h41, 1'b0, 8'h00, exp_init_cyc + 1);
        wait_acks(1);

        // Clear command takes the long wait; a display-control command the short one.
        do_round(2, 1'b0, 8'h00, 1'b0, 8'h01);
        do_round(2, 1'b0, 8'h00, 1'b0, 8'h0C);

        // Both ports held together: alternating service.
        do_round(3, 1'b0, 8'h80, 1'b1, 8'h42);
        do_round(3, 1'b1, 8'h43, 1'b0, 8'h28);

        // Random traffic, biased toward the clear/home boundary commands.
        for (int i = 0; i < 14; i++) begin
            pat = int'($urandom_range(1, 3));
            r0  = 1'($urandom_range(0, 1));
            r1  = 1'($urandom_range(0, 1));
            d0  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            d1  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            repeat ($urandom_range(0, 40)) @(negedge clock);
            do_round(pat, r0, d0, r1, d1);
        end

        // Reset while LCD_E is high in the middle of a byte.
        wait_ready(2000);
        do_round(1, 1'b1, 8'h55, 1'b0, 8'h00);
        n = 0;
        while (!LCD_E && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("e_seen_before_reset", int'(LCD_E), 1);
        repeat (3) @(negedge clock);
        do_reset(2);
        n = 0;
        while (!init_done && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("reinit_done", int'(init_done), 1);
        do_round(3, 1'b0, 8'h02, 1'b1, 8'h7A);

        // Drain and confirm every expected event was seen.
        n = 0;
        while ((!ready || pulse_q.size() != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(negedge clock);
        chk("grants_left", exp_q.size(), 0);
        chk("pulses_left", pulse_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
